// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared code points, segment table and state encoding for the
//           PIO-driven BCD display.
// Rev     : 1.0  initial release
// ============================================================================
package bcd_pkg;

    localparam logic [3:0] BCD_SEP   = 4'hE;
    localparam logic [3:0] BCD_CLR   = 4'hF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9.
    localparam logic [6:0] SEG_CODES [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUAL   = 2'd1,
        COMMIT = 2'd2
    } disp_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] bcd;
    } slot_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module  : bcd_to_seg7
// Brief   : Combinational {valid, bcd} to active-low seven-segment decoder.
// Rev     : 1.0  initial release
// ============================================================================
module bcd_to_seg7
    import bcd_pkg::*;
(
    input  logic       i_valid,
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_valid && is_digit(i_bcd)) begin
            o_seg = SEG_CODES[i_bcd];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pio_bcd_display.sv
`default_nettype none
// ============================================================================
// Module  : pio_bcd_display
// Brief   : Qualifies PIO codes and shifts committed BCD digits into a
//           right-entry seven-segment display with registered outputs.
// Rev     : 1.0  initial release
// ============================================================================
module pio_bcd_display
    import bcd_pkg::*;
#(
    parameter int DIGITS        = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic [3:0]                    pio_bcd,
    output logic [7*DIGITS-1:0]           hex_n,
    output logic [$clog2(DIGITS+1)-1:0]   digit_count,
    output logic                          push_pulse,
    output logic                          err
);

    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [STAB_W-1:0] c_stab_max  = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] c_stab_one  = STAB_W'(1);
    localparam logic [CNT_W-1:0]  c_count_max = CNT_W'(DIGITS);

    disp_state_t         r_state;
    logic [3:0]          r_last;
    logic [3:0]          r_cand;
    logic [STAB_W-1:0]   r_stab_cnt;
    slot_t               r_slot [DIGITS];
    logic [CNT_W-1:0]    r_count;
    logic                r_err;
    logic [7*DIGITS-1:0] r_hex;

    slot_t               w_slot_next [DIGITS];
    logic [7*DIGITS-1:0] w_seg;
    logic                w_commit;
    logic                w_commit_digit;
    logic                w_commit_clr;
    logic                w_commit_inval;

    assign w_commit       = (r_state == COMMIT);
    assign w_commit_digit = w_commit && is_digit(r_cand);
    assign w_commit_clr   = w_commit && (r_cand == BCD_CLR);
    assign w_commit_inval = w_commit && !is_digit(r_cand)
                            && (r_cand != BCD_SEP) && (r_cand != BCD_CLR);

    // Qualification: a code must stay put for STABLE_CYCLES checks in QUAL.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state    <= IDLE;
            r_last     <= 4'h0;
            r_cand     <= 4'h0;
            r_stab_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pio_bcd != r_last) begin
                        r_cand     <= pio_bcd;
                        r_stab_cnt <= c_stab_one;
                        r_state    <= QUAL;
                    end
                end
                QUAL: begin
                    if (pio_bcd != r_cand) begin
                        r_cand     <= pio_bcd;
                        r_stab_cnt <= c_stab_one;
                    end else if (pio_bcd == r_last) begin
                        r_state <= IDLE;
                    end else if (r_stab_cnt == c_stab_max) begin
                        r_state <= COMMIT;
                    end else begin
                        r_stab_cnt <= r_stab_cnt + c_stab_one;
                    end
                end
                COMMIT: begin
                    r_last  <= r_cand;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            w_slot_next[k] = r_slot[k];
        end
        if (w_commit_clr) begin
            for (int k = 0; k < DIGITS; k++) begin
                w_slot_next[k] = '0;
            end
        end else if (w_commit_digit) begin
            w_slot_next[0] = '{valid: 1'b1, bcd: r_cand};
            for (int k = 1; k < DIGITS; k++) begin
                w_slot_next[k] = r_slot[k-1];
            end
        end
    end

    // Decoding the next-state slots lets hex_n land together with the slots.
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            bcd_to_seg7 u_seg (
                .i_valid (w_slot_next[k].valid),
                .i_bcd   (w_slot_next[k].bcd),
                .o_seg   (w_seg[7*k +: 7])
            );
        end
    endgenerate

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int k = 0; k < DIGITS; k++) begin
                r_slot[k] <= '0;
            end
            r_count <= '0;
            r_err   <= 1'b0;
            r_hex   <= '1;
        end else begin
            for (int k = 0; k < DIGITS; k++) begin
                r_slot[k] <= w_slot_next[k];
            end
            r_hex <= w_seg;
            if (w_commit_clr) begin
                r_count <= '0;
                r_err   <= 1'b0;
            end else begin
                if (w_commit_digit && (r_count != c_count_max)) begin
                    r_count <= r_count + CNT_W'(1);
                end
                if (w_commit_inval) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign hex_n       = r_hex;
    assign digit_count = r_count;
    assign err         = r_err;
    assign push_pulse  = w_commit_digit;

endmodule
`default_nettype wire
